// File: rtl/cache_pkg.sv
// Shared types and constants for the cache fill controller and its helpers.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_BITS = 3;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/cache_fill_ctrl_word_counter.sv
// Block word-offset counter: synchronous clear beats enable; tc flags the last word.
module word_counter
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    output logic [OFFSET_BITS-1:0] count,
    output logic                   tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == OFFSET_BITS'(BLOCK_WORDS - 1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss/stall responder: streams 8-word block fills from memory into the I or D cache
// and performs single-cycle write-through stores.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_miss,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic              data_miss,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              fill_sel,
    output logic              fill_wen,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_word,
    output logic              tag_wen,
    output logic              F_stall,
    output logic              M_stall
);

    localparam int BASE_LSB = $clog2(BLOCK_WORDS) + 1;
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((32'd1 << BASE_LSB) - 32'd1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] base_reg;     // block-aligned address of the fill in progress
    logic              sel_reg;
    logic              issued_reg;   // all reads of the block have been issued

    logic [OFFSET_BITS-1:0] issue_cnt, rx_cnt;
    logic                   issue_tc, rx_tc;
    logic                   cnt_clr, issue_en, rx_en;
    logic [ADDR_W-1:0]      issue_off, rx_off;

    assign cnt_clr  = (state_reg != FILL);
    assign issue_en = (state_reg == FILL) && !issued_reg;
    assign rx_en    = (state_reg == FILL) && mem_rvalid;

    word_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (issue_en),
        .count (issue_cnt),
        .tc    (issue_tc)
    );

    word_counter u_rx_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (rx_en),
        .count (rx_cnt),
        .tc    (rx_tc)
    );

    assign issue_off = {{(ADDR_W-OFFSET_BITS-1){1'b0}}, issue_cnt, 1'b0};
    assign rx_off    = {{(ADDR_W-OFFSET_BITS-1){1'b0}}, rx_cnt, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            base_reg   <= '0;
            sel_reg    <= SEL_I;
            issued_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            // D side is the older instruction, so it wins over a concurrent I miss
            if (state_reg == IDLE && !data_wr) begin
                if (data_miss) begin
                    base_reg <= data_addr & BASE_MASK;
                    sel_reg  <= SEL_D;
                end else if (instr_miss) begin
                    base_reg <= instr_addr & BASE_MASK;
                    sel_reg  <= SEL_I;
                end
            end
            if (state_reg != FILL) begin
                issued_reg <= 1'b0;
            end else if (issue_en && issue_tc) begin
                issued_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_sel   = SEL_I;
        fill_wen   = 1'b0;
        fill_addr  = '0;
        fill_word  = '0;
        tag_wen    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (data_wr) begin
                    state_next = WRITE;
                end else if (data_miss || instr_miss) begin
                    state_next = FILL;
                end
            end
            WRITE: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = data_addr;
                mem_wdata  = data_wdata;
                state_next = IDLE;
            end
            FILL: begin
                fill_sel = sel_reg;
                if (!issued_reg) begin
                    mem_en   = 1'b1;
                    mem_addr = base_reg | issue_off;
                end
                if (mem_rvalid) begin
                    fill_wen  = 1'b1;
                    fill_addr = base_reg | rx_off;
                    fill_word = mem_rdata;
                    if (rx_tc) begin
                        tag_wen    = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign F_stall = instr_miss || (state_reg != IDLE);
    assign M_stall = data_miss
                  || (data_wr && (state_reg == IDLE))
                  || ((state_reg != IDLE) && (state_reg != DONE) && (sel_reg == SEL_D))
                  || (state_reg == WRITE);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl with an in-order, variable-latency memory model.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_miss, data_miss, data_wr, mem_rvalid;
    logic [15:0] instr_addr, data_addr, data_wdata, mem_rdata;
    logic        mem_en, mem_wr, fill_sel, fill_wen, tag_wen, F_stall, M_stall;
    logic [15:0] mem_addr, mem_wdata, fill_addr, fill_word;

    cache_fill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .instr_miss (instr_miss),
        .instr_addr (instr_addr),
        .data_miss  (data_miss),
        .data_wr    (data_wr),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .fill_sel   (fill_sel),
        .fill_wen   (fill_wen),
        .fill_addr  (fill_addr),
        .fill_word  (fill_word),
        .tag_wen    (tag_wen),
        .F_stall    (F_stall),
        .M_stall    (M_stall)
    );

    always #5 clk = ~clk;

    typedef struct { logic wr; logic [15:0] addr; logic [15:0] wdata; } mem_exp_t;
    typedef struct { logic sel; logic [15:0] addr; logic [15:0] word; logic tag; } fill_exp_t;
    typedef struct { logic [15:0] addr; int ready; } pend_t;

    mem_exp_t  exp_mem[$];
    fill_exp_t exp_fill[$];
    pend_t     pend[$];

    int checks = 0, failures = 0;
    int cyc = 0, lat = 4, last_ready = 0;
    int tag_cyc = -1, read_mark = -1, write_mark = -1, fill_cnt = 0;
    bit irregular = 0, stray_on = 0, chk_fstall = 0, tag_seen = 0;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a * 16'd3) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_fill(input logic sel, input logic [15:0] addr);
        for (int i = 0; i < 8; i++) begin
            mem_exp_t  m;
            fill_exp_t f;
            logic [15:0] a;
            a = {addr[15:4], 4'(i * 2)};
            m.wr = 1'b0; m.addr = a; m.wdata = '0;
            f.sel = sel; f.addr = a; f.word = mem_fn(a); f.tag = (i == 7);
            exp_mem.push_back(m);
            exp_fill.push_back(f);
        end
    endtask

    // Observe one cycle's outputs at the falling edge.
    task automatic sample_phase();
        @(negedge clk);
        if (mem_en) begin
            $display("cyc=%0d mem wr=%0b addr=%h wdata=%h", cyc, mem_wr, mem_addr, mem_wdata);
            if (exp_mem.size() == 0) begin
                check("mem_unexpected", 1, 0);
            end else begin
                mem_exp_t e;
                e = exp_mem.pop_front();
                check("mem_wr", mem_wr, e.wr);
                check("mem_addr", mem_addr, e.addr);
                if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
            end
            if (!mem_wr) begin
                pend_t p;
                if (read_mark < 0) read_mark = cyc;
                p.addr  = mem_addr;
                p.ready = cyc + lat;
                if (p.ready <= last_ready) p.ready = last_ready + 1;
                if (irregular) p.ready += int'($urandom_range(0, 3));
                last_ready = p.ready;
                pend.push_back(p);
            end else begin
                write_mark = cyc;
            end
        end
        if (fill_wen) begin
            $display("cyc=%0d fill sel=%0b addr=%h word=%h tag=%0b", cyc, fill_sel, fill_addr, fill_word, tag_wen);
            fill_cnt++;
            if (exp_fill.size() == 0) begin
                check("fill_unexpected", 1, 0);
            end else begin
                fill_exp_t f;
                f = exp_fill.pop_front();
                check("fill_sel", fill_sel, f.sel);
                check("fill_addr", fill_addr, f.addr);
                check("fill_word", fill_word, f.word);
                check("tag_wen", tag_wen, f.tag);
            end
        end else if (tag_wen) begin
            check("tag_without_fill", 1, 0);
        end
        if (tag_wen) begin
            tag_seen = 1;
            tag_cyc  = cyc;
        end
        if (chk_fstall) check("f_stall_hold", F_stall, 1);
    endtask

    // Move to the next cycle and present this cycle's memory response.
    task automatic advance_phase();
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() > 0 && pend[0].ready <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_fn(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            mem_rvalid = stray_on;
            mem_rdata  = 16'hDEAD;
        end
    endtask

    task automatic do_cycle();
        sample_phase();
        advance_phase();
    endtask

    task automatic wait_tag(input int budget);
        tag_seen = 0;
        for (int n = 0; n < budget && !tag_seen; n++) do_cycle();
        check("tag_timeout", tag_seen, 1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_mem_left"}, exp_mem.size(), 0);
        check({tag, "_fill_left"}, exp_fill.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1;
        instr_miss = 0; data_miss = 0; data_wr = 0; mem_rvalid = 0;
        instr_addr = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", {mem_en, mem_wr, fill_wen, tag_wen, fill_sel, F_stall, M_stall}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fill_addr", fill_addr, 0);
        rst = 1'b0;
        cyc = 0;

        // I-miss, 4-cycle memory, latency profile
        c0 = cyc;
        instr_miss = 1; instr_addr = 16'h0124;
        push_fill(1'b0, 16'h0124);
        read_mark = -1; chk_fstall = 1;
        wait_tag(60);
        check("imiss_first_issue", read_mark, c0 + 1);
        check("imiss_tag_cycle", tag_cyc, c0 + 12);
        sample_phase();
        check("done_fstall", F_stall, 1);
        check("done_mem_en", mem_en, 0);
        check("done_fill_wen", fill_wen, 0);
        check("done_cycle", cyc, c0 + 13);
        advance_phase();
        chk_fstall = 0; instr_miss = 0;
        sample_phase();
        check("hit_fstall", F_stall, 0);
        check("hit_mem_en", mem_en, 0);
        advance_phase();
        check_drained("imiss");

        // Concurrent D and I misses: D first
        data_miss = 1; data_addr = 16'h4006;
        instr_miss = 1; instr_addr = 16'h0010;
        push_fill(1'b1, 16'h4006);
        push_fill(1'b0, 16'h0010);
        chk_fstall = 1;
        sample_phase();
        check("dual_mstall", M_stall, 1);
        advance_phase();
        wait_tag(60);
        do_cycle();
        data_miss = 0;
        sample_phase();
        check("dual_mstall_released", M_stall, 0);
        advance_phase();
        wait_tag(60);
        do_cycle();
        chk_fstall = 0; instr_miss = 0;
        do_cycle();
        check_drained("dual");

        // Store with a pending I miss
        c0 = cyc;
        data_wr = 1; data_addr = 16'h2002; data_wdata = 16'hBEEF;
        instr_miss = 1; instr_addr = 16'h0300;
        exp_mem.push_back('{wr: 1'b1, addr: 16'h2002, wdata: 16'hBEEF});
        push_fill(1'b0, 16'h0300);
        read_mark = -1; write_mark = -1;
        sample_phase();
        check("store_mstall_idle", M_stall, 1);
        advance_phase();
        data_wr = 0;
        sample_phase();
        check("store_mem_wr", mem_wr, 1);
        check("store_mstall_write", M_stall, 1);
        advance_phase();
        wait_tag(60);
        check("store_write_cycle", write_mark, c0 + 1);
        check("store_ifill_issue", read_mark, c0 + 3);
        do_cycle();
        instr_miss = 0; data_addr = '0; data_wdata = '0;
        do_cycle();
        check_drained("store");

        // Irregular response gaps
        irregular = 1;
        data_miss = 1; data_addr = 16'h1234;
        push_fill(1'b1, 16'h1234);
        wait_tag(100);
        do_cycle();
        data_miss = 0;
        do_cycle();
        irregular = 0;
        check_drained("irregular");

        // Reset after 3 of 8 words
        instr_miss = 1; instr_addr = 16'h0800;
        push_fill(1'b0, 16'h0800);
        fill_cnt = 0; tag_seen = 0;
        for (int n = 0; n < 40 && fill_cnt < 3; n++) do_cycle();
        check("abort_words_before_rst", fill_cnt, 3);
        rst = 1'b1;
        #1;
        check("abort_mem_en", mem_en, 0);
        check("abort_fill_wen", fill_wen, 0);
        check("abort_tag_wen", tag_wen, 0);
        check("abort_mem_addr", mem_addr, 0);
        exp_mem.delete(); exp_fill.delete(); pend.delete();
        last_ready = 0;
        instr_miss = 0; stray_on = 1;
        do_cycle();
        do_cycle();
        rst = 1'b0;
        repeat (3) do_cycle();
        check("abort_no_tag", tag_seen, 0);

        // Stray rvalid while idle
        sample_phase();
        check("idle_stray_fill_wen", fill_wen, 0);
        check("idle_stray_mem_en", mem_en, 0);
        check("idle_stray_fstall", F_stall, 0);
        advance_phase();
        stray_on = 0;
        do_cycle();

        // Fresh D fill after all that still starts at offset 0
        lat = 2;
        data_miss = 1; data_addr = 16'hFFFE;
        push_fill(1'b1, 16'hFFFE);
        wait_tag(60);
        do_cycle();
        data_miss = 0;
        do_cycle();
        check_drained("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
